// File: rtl/fetch_pc_ctrl_pkg.sv
// ============================================================================
// Module      : fetch_pc_ctrl_pkg
// Description : Shared fetch-stage types and constants: stall and exception
//               encodings, datapath width and system-instruction opcodes.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package fetch_pc_ctrl_pkg;

  localparam int XLEN = 32;

  // Pipeline stall reason; any value other than NO_STALL freezes fetch
  typedef enum logic [1:0] {
    NO_STALL = 2'd0,
    STALL_1  = 2'd1,
    STALL_2  = 2'd2,
    STALL_3  = 2'd3
  } stall_e;

  // Fetch-stage exception causes (values match the trap cause codes)
  typedef enum logic [3:0] {
    INSTR_MISALIGNED    = 4'd0,
    INSTR_ACCESS_FAULT  = 4'd1,
    ILLEGAL_INSTRUCTION = 4'd2,
    EBREAK              = 4'd3,
    ECALL               = 4'd11,
    NO_EXCEPTION        = 4'd15
  } exc_type_e;

  localparam logic [31:0] c_EBREAK_INSN = 32'h0010_0073;
  localparam logic [31:0] c_ECALL_INSN  = 32'h0000_0073;

endpackage

`default_nettype wire

// File: rtl/fetch_pc_ctrl.sv
// ============================================================================
// Module      : fetch_pc_ctrl
// Description : Instruction-fetch control core. Owns the PC register, picks
//               the next PC (trap / redirect / prediction / sequential),
//               drives the align-buffer request, raises the I-miss stall,
//               classifies fetch exceptions and turns the buffer's level
//               I-cache request into a one-shot request.
//               Optional macro FETCH_TRACER_EN adds fe_tracer_inst_o.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fetch_pc_ctrl #(
  parameter logic [31:0] RESET_VECTOR = 32'h8000_0000,
  parameter int          XLEN         = 32
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic [1:0]      stall_i,
  input  logic            flush_i,
  input  logic            trap_active_i,
  input  logic [XLEN-1:0] ex_mtvec_i,
  input  logic            spec_hit_i,
  input  logic [XLEN-1:0] pc_target_i,
  input  logic            spec_taken_i,
  input  logic [XLEN-1:0] spec_pc_i,
  input  logic            buf_valid_i,
  input  logic [XLEN-1:0] buf_blk_i,
  input  logic [XLEN-1:0] inst_i,
  input  logic            is_comp_i,
  input  logic            illegal_i,
  input  logic            pma_grant_i,
  input  logic            pma_uncached_i,
  input  logic            ic_req_valid_i,
  input  logic            ic_res_valid_i,
  input  logic            ic_res_ready_i,
  output logic            ic_req_valid_o,
  output logic [XLEN-1:0] pc_o,
  output logic [XLEN-1:0] pc_incr_o,
  output logic            pc_en_o,
  output logic            breq_valid_o,
  output logic            breq_ready_o,
  output logic [XLEN-1:0] breq_addr_o,
  output logic            breq_uncached_o,
  output logic            imiss_stall_o,
`ifdef FETCH_TRACER_EN
  output logic [31:0]     fe_tracer_inst_o,
`endif
  output logic [3:0]      exc_type_o
);

  import fetch_pc_ctrl_pkg::*;

  logic [XLEN-1:0] r_pc;
  logic            r_ack;
  logic [XLEN-1:0] w_pc_next;
  logic [XLEN-1:0] w_pc_incr;
  logic            w_pc_en;
  logic            w_no_stall;
  logic            w_fetch_valid;
  exc_type_e       w_exc;

  assign w_no_stall    = (stall_i == NO_STALL);
  // A trap must always be able to redirect fetch, even while stalled/flushed
  assign w_pc_en       = trap_active_i | (w_no_stall & ~flush_i);
  assign w_fetch_valid = ~flush_i & ~trap_active_i;

  // Sequential increment: half-word step only when a compressed instruction is present
  always_comb begin
    w_pc_incr = r_pc + XLEN'(4);
    if (buf_valid_i && is_comp_i) begin
      w_pc_incr = r_pc + XLEN'(2);
    end
  end

  // Next-PC selection: trap > mispredict redirect > predicted taken > sequential
  always_comb begin
    w_pc_next = w_pc_incr;
    if (trap_active_i) begin
      w_pc_next = ex_mtvec_i;
    end else if (!spec_hit_i) begin
      w_pc_next = pc_target_i;
    end else if (spec_taken_i) begin
      w_pc_next = spec_pc_i;
    end
  end

  // PC register
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_pc <= RESET_VECTOR;
    end else if (w_pc_en) begin
      r_pc <= w_pc_next;
    end
  end

  // Fetch exception classification, first match wins
  always_comb begin
    w_exc = NO_EXCEPTION;
    if (!w_fetch_valid) begin
      w_exc = NO_EXCEPTION;
    end else if (r_pc[0]) begin
      w_exc = INSTR_MISALIGNED;
    end else if (!pma_grant_i) begin
      w_exc = INSTR_ACCESS_FAULT;
    end else if (illegal_i && buf_valid_i) begin
      w_exc = ILLEGAL_INSTRUCTION;
    end else if (inst_i == c_EBREAK_INSN) begin
      w_exc = EBREAK;
    end else if (inst_i == c_ECALL_INSN) begin
      w_exc = ECALL;
    end
  end

  // Request-acknowledged flag: set once a request is accepted, cleared by a
  // response so the next request can go out the following cycle
  always_ff @(posedge clk_i) begin
    if (!rst_ni || flush_i) begin
      r_ack <= 1'b0;
    end else if (ic_res_valid_i) begin
      r_ack <= 1'b0;
    end else if (!r_ack) begin
      r_ack <= ic_req_valid_i & ic_res_ready_i;
    end
  end

  assign ic_req_valid_o  = ic_req_valid_i & ~r_ack;
  assign pc_o            = r_pc;
  assign pc_incr_o       = w_pc_incr;
  assign pc_en_o         = w_pc_en;
  assign breq_valid_o    = w_fetch_valid;
  assign breq_ready_o    = ~flush_i & rst_ni;
  assign breq_addr_o     = r_pc;
  assign breq_uncached_o = pma_uncached_i;
  assign imiss_stall_o   = w_fetch_valid & ~buf_valid_i;
  assign exc_type_o      = w_exc;

`ifdef FETCH_TRACER_EN
  // Trace the raw fetched bits of the instruction being issued this cycle
  always_comb begin
    fe_tracer_inst_o = 32'h0;
    if (w_no_stall && buf_valid_i) begin
      fe_tracer_inst_o = is_comp_i ? {16'b0, buf_blk_i[15:0]} : buf_blk_i[31:0];
    end
  end
`else
  // Raw buffer bits are only consumed by the tracer
  logic w_unused_blk;
  assign w_unused_blk = ^buf_blk_i;
`endif

endmodule

`default_nettype wire

// File: tb/tb_fetch_pc_ctrl.sv
// ============================================================================
// Module      : tb_fetch_pc_ctrl
// Description : Directed self-checking bench for fetch_pc_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fetch_pc_ctrl;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic [1:0]  stall_i;
  logic        flush_i, trap_active_i, spec_hit_i, spec_taken_i;
  logic [31:0] ex_mtvec_i, pc_target_i, spec_pc_i, buf_blk_i, inst_i;
  logic        buf_valid_i, is_comp_i, illegal_i, pma_grant_i, pma_uncached_i;
  logic        ic_req_valid_i, ic_res_valid_i, ic_res_ready_i;
  logic        ic_req_valid_o, pc_en_o, breq_valid_o, breq_ready_o;
  logic        breq_uncached_o, imiss_stall_o;
  logic [31:0] pc_o, pc_incr_o, breq_addr_o;
  logic [3:0]  exc_type_o;
`ifdef FETCH_TRACER_EN
  logic [31:0] fe_tracer_inst_o;
`endif

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk_i = ~clk_i;

  fetch_pc_ctrl dut (
    .clk_i           (clk_i),
    .rst_ni          (rst_ni),
    .stall_i         (stall_i),
    .flush_i         (flush_i),
    .trap_active_i   (trap_active_i),
    .ex_mtvec_i      (ex_mtvec_i),
    .spec_hit_i      (spec_hit_i),
    .pc_target_i     (pc_target_i),
    .spec_taken_i    (spec_taken_i),
    .spec_pc_i       (spec_pc_i),
    .buf_valid_i     (buf_valid_i),
    .buf_blk_i       (buf_blk_i),
    .inst_i          (inst_i),
    .is_comp_i       (is_comp_i),
    .illegal_i       (illegal_i),
    .pma_grant_i     (pma_grant_i),
    .pma_uncached_i  (pma_uncached_i),
    .ic_req_valid_i  (ic_req_valid_i),
    .ic_res_valid_i  (ic_res_valid_i),
    .ic_res_ready_i  (ic_res_ready_i),
    .ic_req_valid_o  (ic_req_valid_o),
    .pc_o            (pc_o),
    .pc_incr_o       (pc_incr_o),
    .pc_en_o         (pc_en_o),
    .breq_valid_o    (breq_valid_o),
    .breq_ready_o    (breq_ready_o),
    .breq_addr_o     (breq_addr_o),
    .breq_uncached_o (breq_uncached_o),
    .imiss_stall_o   (imiss_stall_o),
`ifdef FETCH_TRACER_EN
    .fe_tracer_inst_o(fe_tracer_inst_o),
`endif
    .exc_type_o      (exc_type_o)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one clock and settle just after the edge
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    rst_ni = 1'b0; stall_i = 2'd0; flush_i = 1'b0; trap_active_i = 1'b0;
    ex_mtvec_i = 32'h0; spec_hit_i = 1'b1; pc_target_i = 32'h0;
    spec_taken_i = 1'b0; spec_pc_i = 32'h0; buf_valid_i = 1'b1;
    buf_blk_i = 32'h1234_5678; inst_i = 32'h0000_0013; is_comp_i = 1'b0;
    illegal_i = 1'b0; pma_grant_i = 1'b1; pma_uncached_i = 1'b0;
    ic_req_valid_i = 1'b0; ic_res_valid_i = 1'b0; ic_res_ready_i = 1'b0;

    // Reset
    tick(); tick();
    check("rst_pc", pc_o, 32'h8000_0000);
    check("rst_breq_ready", {31'b0, breq_ready_o}, 32'd0);
    check("rst_ic_req", {31'b0, ic_req_valid_o}, 32'd0);

    // First cycle out of reset
    rst_ni = 1'b1; #1;
    check("first_pc", pc_o, 32'h8000_0000);
    check("first_breq_valid", {31'b0, breq_valid_o}, 32'd1);
    check("first_breq_ready", {31'b0, breq_ready_o}, 32'd1);
    check("first_pc_incr", pc_incr_o, 32'h8000_0004);
    check("first_imiss", {31'b0, imiss_stall_o}, 32'd0);
    check("first_exc", {28'b0, exc_type_o}, 32'd15);
    tick();
    check("seq_pc4", pc_o, 32'h8000_0004);

    // Compressed advance by 2
    is_comp_i = 1'b1; #1;
    check("comp_incr", pc_incr_o, 32'h8000_0006);
`ifdef FETCH_TRACER_EN
    check("tracer_comp", fe_tracer_inst_o, 32'h0000_5678);
`endif
    tick();
    check("comp_pc", pc_o, 32'h8000_0006);
    is_comp_i = 1'b0;

    // Stall holds PC; trap overrides stall
    stall_i = 2'd1; #1;
    check("stall_en", {31'b0, pc_en_o}, 32'd0);
`ifdef FETCH_TRACER_EN
    check("tracer_stall", fe_tracer_inst_o, 32'h0);
`endif
    tick();
    check("stall_hold", pc_o, 32'h8000_0006);
    trap_active_i = 1'b1; ex_mtvec_i = 32'h8000_0100; #1;
    check("trap_en", {31'b0, pc_en_o}, 32'd1);
    check("trap_breq_valid", {31'b0, breq_valid_o}, 32'd0);
    check("trap_exc", {28'b0, exc_type_o}, 32'd15);
    tick();
    check("trap_pc", pc_o, 32'h8000_0100);
    trap_active_i = 1'b0; stall_i = 2'd0;

    // Mispredict beats prediction, then prediction
    spec_hit_i = 1'b0; pc_target_i = 32'h8000_0040;
    spec_taken_i = 1'b1; spec_pc_i = 32'h8000_0080;
    tick();
    check("redirect_pc", pc_o, 32'h8000_0040);
    spec_hit_i = 1'b1;
    tick();
    check("pred_pc", pc_o, 32'h8000_0080);
    spec_taken_i = 1'b0;

    // Flush: no fetch, no miss stall, no exception
    flush_i = 1'b1; buf_valid_i = 1'b0; inst_i = 32'h0000_0073; #1;
    check("flush_exc", {28'b0, exc_type_o}, 32'd15);
    check("flush_imiss", {31'b0, imiss_stall_o}, 32'd0);
    check("flush_en", {31'b0, pc_en_o}, 32'd0);
    check("flush_breq_ready", {31'b0, breq_ready_o}, 32'd0);
    tick();
    check("flush_hold", pc_o, 32'h8000_0080);
    flush_i = 1'b0; #1;
    check("miss_stall", {31'b0, imiss_stall_o}, 32'd1);
    buf_valid_i = 1'b1; inst_i = 32'h0000_0013;

    // Misaligned PC has priority over access fault
    spec_taken_i = 1'b1; spec_pc_i = 32'h8000_0001;
    tick();
    spec_taken_i = 1'b0; pma_grant_i = 1'b0; #1;
    check("misaligned_pc", pc_o, 32'h8000_0001);
    check("exc_misaligned", {28'b0, exc_type_o}, 32'd0);
    spec_taken_i = 1'b1; spec_pc_i = 32'h8000_0200;
    tick();
    spec_taken_i = 1'b0; stall_i = 2'd2; #1;
    check("exc_access", {28'b0, exc_type_o}, 32'd1);
    pma_grant_i = 1'b1; illegal_i = 1'b1; #1;
    check("exc_illegal", {28'b0, exc_type_o}, 32'd2);
    buf_valid_i = 1'b0; #1;
    check("exc_illegal_nobuf", {28'b0, exc_type_o}, 32'd15);
    buf_valid_i = 1'b1; illegal_i = 1'b0; inst_i = 32'h0010_0073; #1;
    check("exc_ebreak", {28'b0, exc_type_o}, 32'd3);
    inst_i = 32'h0000_0073; #1;
    check("exc_ecall", {28'b0, exc_type_o}, 32'd11);
    inst_i = 32'h0000_0013; pma_uncached_i = 1'b1; #1;
    check("exc_none", {28'b0, exc_type_o}, 32'd15);
    check("breq_uncached", {31'b0, breq_uncached_o}, 32'd1);
    check("breq_addr", breq_addr_o, 32'h8000_0200);
    pma_uncached_i = 1'b0; stall_i = 2'd0;

    // One-shot I-cache request
    ic_req_valid_i = 1'b1; ic_res_ready_i = 1'b1; #1;
    check("ic_first", {31'b0, ic_req_valid_o}, 32'd1);
    tick();
    check("ic_blocked1", {31'b0, ic_req_valid_o}, 32'd0);
    tick();
    check("ic_blocked2", {31'b0, ic_req_valid_o}, 32'd0);
    ic_res_valid_i = 1'b1;
    tick();
    ic_res_valid_i = 1'b0; #1;
    check("ic_rearm", {31'b0, ic_req_valid_o}, 32'd1);
    // Response arriving with the request keeps the flag clear
    ic_res_valid_i = 1'b1;
    tick();
    ic_res_valid_i = 1'b0; #1;
    check("ic_same_cycle_rsp", {31'b0, ic_req_valid_o}, 32'd1);
    tick();
    check("ic_blocked3", {31'b0, ic_req_valid_o}, 32'd0);
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0; #1;
    check("ic_flush_clear", {31'b0, ic_req_valid_o}, 32'd1);
    ic_req_valid_i = 1'b0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
